// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with an optional second (skid) entry, flush,
// freeze enable, and saturating stall / flush performance counters.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16,
  parameter int SKID   = 1
) (
  input  logic              stg_clk,
  input  logic              reset,
  input  logic              stg_ena,
  input  logic              stg_x,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a beat moves when valid and ready are both high at a rising
  // edge; in_ready never depends on in_valid, out_valid never on out_ready.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_main_data, w_main_data_nxt;
  logic [CTRL_W-1:0]   r_main_ctrl, w_main_ctrl_nxt;
  logic [DATA_W-1:0]   r_skid_data, w_skid_data_nxt;
  logic [CTRL_W-1:0]   r_skid_ctrl, w_skid_ctrl_nxt;
  logic [CNT_W-1:0]    r_stall_cnt, r_flush_cnt;
  logic [CNT_W-1:0]    w_stall_nxt, w_flush_nxt;
  logic [CNT_W:0]      w_stall_sum, w_flush_sum;
  logic [1:0]          w_flush_add;
  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_push;
  logic                w_pop;
  logic                w_stall_inc;

  always_comb begin
    w_in_ready = 1'b0;
    if (reset && stg_ena && !stg_x) begin
      if (SKID != 0) w_in_ready = (r_state != ST_TWO);
      else           w_in_ready = (r_state == ST_EMPTY) || out_ready;
    end
  end

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_push      = in_valid && w_in_ready;
  assign w_pop       = w_out_valid && out_ready && stg_ena && !stg_x;

  always_comb begin
    w_state_nxt     = r_state;
    w_main_data_nxt = r_main_data;
    w_main_ctrl_nxt = r_main_ctrl;
    w_skid_data_nxt = r_skid_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    if (stg_x) begin
      w_state_nxt     = ST_EMPTY;
      w_main_data_nxt = '0;
      w_main_ctrl_nxt = '0;
      w_skid_data_nxt = '0;
      w_skid_ctrl_nxt = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_state_nxt     = ST_ONE;
            w_main_data_nxt = in_data;
            w_main_ctrl_nxt = in_ctrl;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            w_main_data_nxt = in_data;
            w_main_ctrl_nxt = in_ctrl;
          end else if (w_push) begin
            w_state_nxt     = ST_TWO;
            w_skid_data_nxt = in_data;
            w_skid_ctrl_nxt = in_ctrl;
          end else if (w_pop) begin
            w_state_nxt     = ST_EMPTY;
            w_main_data_nxt = '0;
            w_main_ctrl_nxt = '0;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_state_nxt     = ST_ONE;
            w_main_data_nxt = r_skid_data;
            w_main_ctrl_nxt = r_skid_ctrl;
            w_skid_data_nxt = '0;
            w_skid_ctrl_nxt = '0;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Counters clamp at all-ones; the extra sum bit flags the overflow.
  assign w_stall_inc = in_valid && !w_in_ready;
  assign w_flush_add = stg_x ? r_state : 2'd0;
  assign w_stall_sum = {1'b0, r_stall_cnt} + {{CNT_W{1'b0}}, w_stall_inc};
  assign w_flush_sum = {1'b0, r_flush_cnt} + {{(CNT_W-1){1'b0}}, w_flush_add};
  assign w_stall_nxt = w_stall_sum[CNT_W] ? {CNT_W{1'b1}} : w_stall_sum[CNT_W-1:0];
  assign w_flush_nxt = w_flush_sum[CNT_W] ? {CNT_W{1'b1}} : w_flush_sum[CNT_W-1:0];

  always_ff @(posedge stg_clk) begin
    if (!reset) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_data <= w_main_data_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      if (cnt_clr) begin
        r_stall_cnt <= '0;
        r_flush_cnt <= '0;
      end else begin
        r_stall_cnt <= w_stall_nxt;
        r_flush_cnt <= w_flush_nxt;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? r_main_data : '0;
  assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;
  assign occupancy = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives one stimulus stream into a skid (SKID=1) and a single-register
// (SKID=0) stage and compares both against a queue-based reference model.
module tb_pipe_stage_reg;

  localparam int DW      = 16;
  localparam int CW      = 4;
  localparam int NW      = 4;
  localparam int W       = DW + CW;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          reset, stg_ena, stg_x, in_valid, out_ready, cnt_clr;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          s_in_ready, s_out_valid, n_in_ready, n_out_valid;
  logic [DW-1:0] s_out_data, n_out_data;
  logic [CW-1:0] s_out_ctrl, n_out_ctrl;
  logic [1:0]    s_occupancy, n_occupancy, s_dbg_state, n_dbg_state;
  logic [NW-1:0] s_stall_cnt, s_flush_cnt, n_stall_cnt, n_flush_cnt;

  int checks   = 0;
  int failures = 0;

  // Model state: held beats in acceptance order, counters as plain integers.
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q0[$];
  int stall_m[2];
  int flush_m[2];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW), .SKID(1)) u_dut_skid (
    .stg_clk(clk), .reset(reset), .stg_ena(stg_ena), .stg_x(stg_x),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_ctrl(s_out_ctrl), .occupancy(s_occupancy), .cnt_clr(cnt_clr),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .dbg_state(s_dbg_state)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW), .SKID(0)) u_dut_noskid (
    .stg_clk(clk), .reset(reset), .stg_ena(stg_ena), .stg_x(stg_x),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
    .out_ctrl(n_out_ctrl), .occupancy(n_occupancy), .cnt_clr(cnt_clr),
    .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt), .dbg_state(n_dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic logic m_in_ready(input int k, input int sz);
    if (!reset || !stg_ena || stg_x) return 1'b0;
    if (k == 1) return (sz < 2);
    return (sz == 0) || out_ready;
  endfunction

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic model_update();
    logic [W-1:0] q[$];
    int sz;
    logic rdy;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) q = exp_q1; else q = exp_q0;
      sz  = q.size();
      rdy = m_in_ready(k, sz);
      if (!reset) begin
        q.delete();
        stall_m[k] = 0;
        flush_m[k] = 0;
      end else begin
        if (cnt_clr) begin
          stall_m[k] = 0;
          flush_m[k] = 0;
        end else begin
          if (in_valid && !rdy) stall_m[k] = sat(stall_m[k] + 1);
          if (stg_x)            flush_m[k] = sat(flush_m[k] + sz);
        end
        if (stg_x) q.delete();
        else begin
          if (sz > 0 && out_ready && stg_ena) void'(q.pop_front());
          if (in_valid && rdy) q.push_back({in_ctrl, in_data});
        end
      end
      if (k == 1) exp_q1 = q; else exp_q0 = q;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] head;
    int sz;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        sz   = exp_q1.size();
        head = (sz > 0) ? exp_q1[0] : '0;
        chk("skid.in_ready",  32'(s_in_ready),  32'(m_in_ready(1, sz)));
        chk("skid.out_valid", 32'(s_out_valid), 32'(sz > 0));
        chk("skid.out_data",  32'(s_out_data),  32'(head[DW-1:0]));
        chk("skid.out_ctrl",  32'(s_out_ctrl),  32'(head[W-1:DW]));
        chk("skid.occupancy", 32'(s_occupancy), 32'(sz));
        chk("skid.stall_cnt", 32'(s_stall_cnt), 32'(stall_m[1]));
        chk("skid.flush_cnt", 32'(s_flush_cnt), 32'(flush_m[1]));
      end else begin
        sz   = exp_q0.size();
        head = (sz > 0) ? exp_q0[0] : '0;
        chk("noskid.in_ready",  32'(n_in_ready),  32'(m_in_ready(0, sz)));
        chk("noskid.out_valid", 32'(n_out_valid), 32'(sz > 0));
        chk("noskid.out_data",  32'(n_out_data),  32'(head[DW-1:0]));
        chk("noskid.out_ctrl",  32'(n_out_ctrl),  32'(head[W-1:DW]));
        chk("noskid.occupancy", 32'(n_occupancy), 32'(sz));
        chk("noskid.stall_cnt", 32'(n_stall_cnt), 32'(stall_m[0]));
        chk("noskid.flush_cnt", 32'(n_flush_cnt), 32'(flush_m[0]));
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    #1;
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input logic ordy, input logic ena, input logic x,
                     input logic clr, input logic rst);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    stg_ena   = ena;
    stg_x     = x;
    cnt_clr   = clr;
    reset     = rst;
    step();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b0; stg_ena = 1'b0; stg_x = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; cnt_clr = 1'b0; in_data = '0; in_ctrl = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_q1.delete(); exp_q0.delete();
    stall_m = '{0, 0};
    flush_m = '{0, 0};

    // Reset held with traffic offered: nothing accepted, nothing counted.
    drv(1, 16'h1111, 4'h1, 1, 1, 1, 1, 0);
    drv(1, 16'h2222, 4'h2, 1, 1, 0, 0, 0);
    chk("rst.stall", 32'(s_stall_cnt), 32'd0);

    // Streaming with free downstream.
    for (int i = 1; i <= 6; i++) drv(1, 16'(i), 4'(i), 1, 1, 0, 0, 1);
    chk("stream.data", 32'(s_out_data), 32'd6);
    chk("stream.occ",  32'(s_occupancy), 32'd1);
    chk("stream.stall", 32'(s_stall_cnt), 32'd0);

    // Backpressure: drain, then A and B fill the skid stage, then stall.
    drv(0, 16'h0, 4'h0, 1, 1, 0, 0, 1);
    drv(1, 16'h00A0, 4'hA, 0, 1, 0, 0, 1);
    drv(1, 16'h00B0, 4'hB, 0, 1, 0, 0, 1);
    chk("bp.occ",   32'(s_occupancy), 32'd2);
    chk("bp.ready", 32'(s_in_ready),  32'd0);
    for (int i = 0; i < 3; i++) drv(1, 16'h00C0, 4'hC, 0, 1, 0, 0, 1);
    chk("bp.stall", 32'(s_stall_cnt), 32'd3);
    drv(0, 16'h0, 4'h0, 1, 1, 0, 0, 1);
    chk("bp.second", 32'(s_out_data), 32'h00B0);
    drv(0, 16'h0, 4'h0, 1, 1, 0, 0, 1);

    // Flush a full stage while a new beat is offered.
    drv(1, 16'h0D01, 4'h3, 0, 1, 0, 0, 1);
    drv(1, 16'h0D02, 4'h4, 0, 1, 0, 0, 1);
    drv(1, 16'h0D03, 4'h5, 0, 1, 1, 0, 1);
    chk("flush.occ",   32'(s_occupancy), 32'd0);
    chk("flush.valid", 32'(s_out_valid), 32'd0);
    chk("flush.data",  32'(s_out_data),  32'd0);
    chk("flush.ctrl",  32'(s_out_ctrl),  32'd0);
    chk("flush.cnt",   32'(s_flush_cnt), 32'd2);
    chk("flush.cnt_noskid", 32'(n_flush_cnt), 32'd1);

    // Freeze with one beat held and counters cleared on the load cycle.
    drv(1, 16'h00AB, 4'h6, 0, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) drv(1, 16'($urandom), 4'($urandom), 1, 0, 0, 0, 1);
    chk("freeze.data",  32'(s_out_data),  32'h00AB);
    chk("freeze.stall", 32'(s_stall_cnt), 32'd5);
    chk("freeze.stall_noskid", 32'(n_stall_cnt), 32'd5);

    // Saturation, then clear while still stalling.
    for (int i = 0; i < 20; i++) drv(1, 16'($urandom), 4'($urandom), 0, 1, 0, 0, 1);
    chk("sat.stall", 32'(s_stall_cnt), 32'(CNT_MAX));
    chk("sat.noskid_ready", 32'(n_in_ready), 32'd0);
    drv(1, 16'h0, 4'h0, 0, 1, 0, 1, 1);
    chk("clr.stall", 32'(s_stall_cnt), 32'd0);

    // Reset in the middle of a stream: held beats vanish uncounted.
    for (int i = 0; i < 3; i++) drv(1, 16'(16'h0100 + i), 4'(i), 1, 1, 0, 0, 1);
    drv(1, 16'h0200, 4'h7, 1, 1, 0, 0, 0);
    chk("rstmid.occ",    32'(n_occupancy), 32'd0);
    chk("rstmid.valid",  32'(s_out_valid), 32'd0);
    chk("rstmid.flush",  32'(n_flush_cnt), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drv(1'($urandom_range(0, 3) != 0), 16'($urandom), 4'($urandom),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) != 0),
          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 29) == 0),
          1'($urandom_range(0, 49) != 0));
    end
    #1;
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_W, 64, payload data width.
- CTRL_W, 8, control-flag width.
- CNT_W, 16, performance-counter width.
- SKID, 1, 1 = two-entry skid buffer; 0 = single register.

REQ-002 Ports (name, direction, width, meaning):
- stg_clk, in, 1, sole clock; all state changes on its rising edge.
- reset, in, 1, synchronous, active-low.
- stg_ena, in, 1, stage enable; low freezes all transfers.
- stg_x, in, 1, flush; discards all held beats.
- in_valid, in, 1, upstream beat valid.
- in_ready, out, 1, stage can accept a beat.
- in_data, in, DATA_W, upstream data.
- in_ctrl, in, CTRL_W, upstream control flags.
- out_valid, out, 1, beat available downstream.
- out_ready, in, 1, downstream accepts.
- out_data, out, DATA_W, head data.
- out_ctrl, out, CTRL_W, head control flags.
- occupancy, out, 2, number of held beats (0..2).
- cnt_clr, in, 1, synchronous clear of both counters.
- stall_cnt, out, CNT_W, input backpressure cycles.
- flush_cnt, out, CNT_W, beats discarded by flush.

Function
REQ-003 Definitions: push = in_valid & in_ready; pop = out_valid & out_ready & stg_ena & !stg_x.
REQ-004 States: EMPTY (occ 0), ONE (main holds a beat), TWO (main and skid hold beats). TWO is reachable only when SKID=1.
REQ-005 in_ready: SKID=1: stg_ena & !stg_x & (state != TWO). SKID=0: stg_ena & !stg_x & (state==EMPTY | out_ready).
REQ-006 out_valid = (state != EMPTY) and is registered. out_data/out_ctrl come from main and are all-zero when EMPTY.
REQ-007 EMPTY: push -> ONE, main <= in.
REQ-008 ONE: push & pop -> ONE, main <= in. Push only -> TWO, skid <= in. Pop only -> EMPTY, main <= 0.
REQ-009 TWO: pop -> ONE, main <= skid, skid <= 0. No pop -> hold.
REQ-010 Ordering: beats leave in acceptance order; no beat is duplicated or dropped except by stg_x.
REQ-011 stg_ena=0 and stg_x=0: all payload registers and state hold; no push or pop.
REQ-012 stg_x=1: next state EMPTY; main and skid (data and ctrl) <= 0. Takes priority over stg_ena and over any pop or push. The input beat in the same cycle is refused (in_ready=0).
REQ-013 Latency: an accepted beat appears on out_* the cycle after acceptance when the stage was EMPTY, or when in ONE with a simultaneous pop.
REQ-014 stall_cnt increments by 1 each cycle in_valid & !in_ready; saturates at 2^CNT_W-1.
REQ-015 flush_cnt increments by occupancy (0, 1 or 2) on each stg_x cycle; saturates at 2^CNT_W-1 (clamps, no wrap).
REQ-016 Counter priority: reset > cnt_clr > increment. With cnt_clr=1, both counters read 0 the next cycle and that cycle's increment is lost.

Reset
REQ-017 reset=0 sampled at an edge forces: state EMPTY, main/skid 0, out_valid 0, out_data 0, out_ctrl 0, occupancy 0, stall_cnt 0, flush_cnt 0.
REQ-018 While reset=0, in_ready=0. Reset mid-transfer discards held beats without counting them in flush_cnt.
REQ-019 Reset overrides stg_x, stg_ena and cnt_clr.

Verification
REQ-020 Streaming, SKID=1: in_valid=1, out_ready=1, data 1,2,3… -> out_data 1,2,3… one cycle later, occupancy stays 1, stall_cnt 0.
REQ-021 Backpressure, SKID=1: out_ready=0, push A then B -> occupancy 2, in_ready 0, stall_cnt +1 per later in_valid cycle. out_ready=1 -> A then B out, in consecutive cycles.
REQ-022 Flush: occupancy 2, stg_x=1 with in_valid=1 -> next cycle occupancy 0, out_valid 0, out_data/out_ctrl 0, flush_cnt=2, new beat not accepted.
REQ-023 Freeze: ONE holding 0xAB, stg_ena=0, out_ready=1 for 5 cycles -> out_data 0xAB held, in_ready 0, stall_cnt +5 with in_valid=1.
REQ-024 Counter saturation: CNT_W=4, 20 backpressure cycles -> stall_cnt=15. cnt_clr with in_valid & !in_ready -> stall_cnt 0 next cycle.
REQ-025 SKID=0: out_ready=0 with ONE -> in_ready 0. Same-cycle out_ready=1 & in_valid=1 -> replace, occupancy stays 1. Reset mid-stream -> all outputs 0, flush_cnt unchanged at 0.
